button_debounce: RTL and testbench
==================================

# button_debounce

Input-conditioning stage directly downstream of the DE0 board pins and upstream of all user logic inside the top level. Takes the raw, active-low, bouncing `BUTTON` pushbuttons, synchronises them to the 50 MHz clock and debounces each one independently. Produces clean active-high levels plus single-cycle press and release pulses. Optional auto-repeat is provided for menu and counter style controls.

## Interface
- `N`, 3: number of button channels.
- `TICK_CYCLES`, 50000: clock cycles per debounce tick (1 ms at 50 MHz).
- `DEBOUNCE_TICKS`, 10: consecutive stable ticks required to accept a change.
- `REPEAT_DELAY_TICKS`, 500: hold time before the first auto-repeat pulse.
- `REPEAT_RATE_TICKS`, 100: period between later auto-repeat pulses.

Ports:
- `CLOCK_50` input 1: system clock. Single clock domain.
- `RESET_N` input 1: reset, asynchronous, active-low.
- `BUTTON_N` input N: raw pushbuttons, 0 = pressed, asynchronous to the clock.
- `BTN_LEVEL` output N: debounced state, 1 = pressed.
- `BTN_PRESS` output N: one-cycle pulse on an accepted press (and on each repeat, if enabled).
- `BTN_RELEASE` output N: one-cycle pulse on an accepted release.

## Operation
- **Synchroniser:** a 2-flop synchroniser per channel. `s[i]` is the inverted second flop, so 1 = pressed.
- **Prescaler:** a shared free-running counter, 0 to `TICK_CYCLES`-1. `tick` is high for one cycle when the count equals `TICK_CYCLES`-1, and the counter then wraps to 0.
- **Per-channel FSM:** states RELEASED, PRESS_PEND, HELD, RELEASE_PEND, with a tick counter `cnt` of width clog2(`DEBOUNCE_TICKS`+1).
  - RELEASED: if `s`=1, go to PRESS_PEND with `cnt`=0.
  - PRESS_PEND: if `s`=0, return to RELEASED with no pulse (glitch rejected). Otherwise `cnt` increments on each `tick`. When `cnt` reaches `DEBOUNCE_TICKS`, go to HELD and assert `BTN_PRESS`.
  - HELD: if `s`=0, go to RELEASE_PEND with `cnt`=0.
  - RELEASE_PEND: if `s`=1, return to HELD with no pulse. When `cnt` reaches `DEBOUNCE_TICKS`, go to RELEASED and assert `BTN_RELEASE`.
- **Level output:** `BTN_LEVEL`=1 in HELD and RELEASE_PEND; 0 in RELEASED and PRESS_PEND.
- **Input priority:** the `s` comparison takes priority over `tick` in the same cycle. An input change cancels the pending count.
- **Channel independence:** channels are fully independent. Simultaneous presses on several channels produce simultaneous pulses.
- **No wrap:** counters saturate by construction; the FSM leaves the pending state at terminal count.

## Timing
- **Reset values:** all outputs 0; every FSM in RELEASED; prescaler 0; synchroniser flops 1 (released).
- **Synchroniser latency:** 2 cycles from a pin change to `s`.
- **Acceptance latency:** from `s` becoming stable, acceptance takes between (`DEBOUNCE_TICKS`-1)·`TICK_CYCLES`+1 and `DEBOUNCE_TICKS`·`TICK_CYCLES` cycles, depending on prescaler phase.
- **Output registering:** `BTN_PRESS`, `BTN_RELEASE` and `BTN_LEVEL` are registered. They change in the cycle after the terminal tick. Pulses are exactly 1 cycle wide.
- **Reset while held:** a button held through reset deassertion is treated as a new press, giving one `BTN_PRESS` after debounce.
- **Reset mid-pending:** the pending count is discarded and no pulse is emitted.

## Configuration
- `BUTTON_DEBOUNCE_REPEAT_EN` defined:
  - HELD owns a repeat counter.
  - After `REPEAT_DELAY_TICKS` ticks in HELD, `BTN_PRESS` pulses again, then every `REPEAT_RATE_TICKS` ticks.
  - The counter resets on entry to HELD and is frozen in RELEASE_PEND.
  - A return from RELEASE_PEND to HELD resumes the counter without restarting it.
- Undefined: exactly one `BTN_PRESS` per accepted press. No repeat counter logic is synthesised, and the `REPEAT_*` parameters are ignored.

## Structure
- **Package `de0_input_pkg`:** the channel state enum (RELEASED, PRESS_PEND, HELD, RELEASE_PEND) and default tick constants for 50 MHz.
- **Sub-module `debounce_channel`:** one channel, containing the synchroniser, FSM, counters and output registers. It takes `tick` as an input.
- **Top `button_debounce`:** holds the shared prescaler and instantiates `debounce_channel` N times with a generate loop.

## Test plan
Bench parameters: `TICK_CYCLES`=4, `DEBOUNCE_TICKS`=3, `REPEAT_DELAY_TICKS`=5, `REPEAT_RATE_TICKS`=2.
- **Clean press:** hold `BUTTON_N[0]`=0 for 40 cycles. One `BTN_PRESS[0]` pulse arrives 11–14 cycles after the pin edge, and `BTN_LEVEL[0]` rises the same cycle.
- **Bounce rejection:** toggle `BUTTON_N[1]` every 5 cycles for 60 cycles, then release. No pulses and `BTN_LEVEL[1]`=0 throughout.
- **Release:** after the clean press, set the pin to 1. One `BTN_RELEASE[0]` pulse arrives 11–14 cycles later and `BTN_LEVEL[0]` falls.
- **Simultaneous press:** press all three buttons in the same cycle. `BTN_PRESS`=3'b111 for exactly one cycle.
- **Reset mid-pending:** pull `RESET_N` low during PRESS_PEND. Outputs go to 0 immediately. A button still held after reset gives exactly one press pulse after debounce.
- **Auto-repeat (`BUTTON_DEBOUNCE_REPEAT_EN`):** hold for 60 cycles. Pulses occur at acceptance, then 20 cycles later, then every 8 cycles. Without the macro, only a single pulse.

Source files
------------

// File: rtl/de0_input_pkg.sv
// Shared types and 50 MHz default timing constants for DE0 input conditioning.
package de0_input_pkg;

  // Debounce channel state.
  typedef enum logic [1:0] {
    StReleased    = 2'd0,
    StPressPend   = 2'd1,
    StHeld        = 2'd2,
    StReleasePend = 2'd3
  } chan_state_e;

  // 1 ms tick at 50 MHz, 10 ms debounce, 500 ms first repeat, 100 ms repeat period.
  localparam int unsigned DefaultTickCycles       = 50000;
  localparam int unsigned DefaultDebounceTicks    = 10;
  localparam int unsigned DefaultRepeatDelayTicks = 500;
  localparam int unsigned DefaultRepeatRateTicks  = 100;

  // Bits needed to hold values 0..max_val (never less than 1).
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One pushbutton channel: 2-flop synchroniser, debounce FSM, tick counters and
// registered level / press / release outputs. Auto-repeat logic exists only when
// BUTTON_DEBOUNCE_REPEAT_EN is defined.
module debounce_channel
  import de0_input_pkg::*;
#(
  parameter int unsigned DebounceTicks    = DefaultDebounceTicks,
  parameter int unsigned RepeatDelayTicks = DefaultRepeatDelayTicks,
  parameter int unsigned RepeatRateTicks  = DefaultRepeatRateTicks
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic tick_i,
  input  logic button_ni,
  output logic level_o,
  output logic press_o,
  output logic release_o
);

  localparam int unsigned CntW = cnt_width(DebounceTicks);
  // Acceptance happens on the tick that would bring the count to DebounceTicks.
  localparam logic [CntW-1:0] CntLast = CntW'(DebounceTicks - 1);

  logic            sync1_q, sync2_q;
  logic            s;
  chan_state_e     state_q;
  logic [CntW-1:0] cnt_q;
  logic            level_q, press_q, release_q;

`ifdef BUTTON_DEBOUNCE_REPEAT_EN
  localparam int unsigned RptMax = (RepeatDelayTicks > RepeatRateTicks) ?
                                   RepeatDelayTicks : RepeatRateTicks;
  localparam int unsigned RptW = cnt_width(RptMax);
  localparam logic [RptW-1:0] RptDelayLast = RptW'(RepeatDelayTicks - 1);
  localparam logic [RptW-1:0] RptRateLast  = RptW'(RepeatRateTicks - 1);

  logic [RptW-1:0] rpt_cnt_q;
  // Set until the first repeat fires; selects delay vs. rate terminal count.
  logic            rpt_first_q;
`endif

  // Synchronise the raw pin; flops reset to 1 so a held button reads as a new press.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= button_ni;
      sync2_q <= sync1_q;
    end
  end

  assign s = ~sync2_q;

  // Debounce FSM; an input change always wins over a tick in the same cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= StReleased;
      cnt_q     <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
`ifdef BUTTON_DEBOUNCE_REPEAT_EN
      rpt_cnt_q   <= '0;
      rpt_first_q <= 1'b1;
`endif
    end else begin
      press_q   <= 1'b0;
      release_q <= 1'b0;
      unique case (state_q)
        StReleased: begin
          if (s) begin
            state_q <= StPressPend;
            cnt_q   <= '0;
          end
        end
        StPressPend: begin
          if (!s) begin
            state_q <= StReleased;
          end else if (tick_i) begin
            if (cnt_q == CntLast) begin
              state_q <= StHeld;
              level_q <= 1'b1;
              press_q <= 1'b1;
`ifdef BUTTON_DEBOUNCE_REPEAT_EN
              rpt_cnt_q   <= '0;
              rpt_first_q <= 1'b1;
`endif
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        StHeld: begin
          if (!s) begin
            state_q <= StReleasePend;
            cnt_q   <= '0;
          end
`ifdef BUTTON_DEBOUNCE_REPEAT_EN
          else if (tick_i) begin
            if (rpt_first_q ? (rpt_cnt_q == RptDelayLast) : (rpt_cnt_q == RptRateLast)) begin
              press_q     <= 1'b1;
              rpt_cnt_q   <= '0;
              rpt_first_q <= 1'b0;
            end else begin
              rpt_cnt_q <= rpt_cnt_q + 1'b1;
            end
          end
`endif
        end
        StReleasePend: begin
          // Repeat counter is left untouched here so a bounce back to HELD resumes it.
          if (s) begin
            state_q <= StHeld;
          end else if (tick_i) begin
            if (cnt_q == CntLast) begin
              state_q   <= StReleased;
              level_q   <= 1'b0;
              release_q <= 1'b1;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        default: state_q <= StReleased;
      endcase
    end
  end

  assign level_o   = level_q;
  assign press_o   = press_q;
  assign release_o = release_q;

endmodule

// File: rtl/button_debounce.sv
// DE0 pushbutton conditioning: shared tick prescaler plus N independent debounce
// channels. Define BUTTON_DEBOUNCE_REPEAT_EN to enable auto-repeat press pulses.
module button_debounce
  import de0_input_pkg::*;
#(
  parameter int unsigned N                  = 3,
  parameter int unsigned TICK_CYCLES        = DefaultTickCycles,
  parameter int unsigned DEBOUNCE_TICKS     = DefaultDebounceTicks,
  parameter int unsigned REPEAT_DELAY_TICKS = DefaultRepeatDelayTicks,
  parameter int unsigned REPEAT_RATE_TICKS  = DefaultRepeatRateTicks
) (
  input  logic         CLOCK_50,
  input  logic         RESET_N,
  input  logic [N-1:0] BUTTON_N,
  output logic [N-1:0] BTN_LEVEL,
  output logic [N-1:0] BTN_PRESS,
  output logic [N-1:0] BTN_RELEASE
);

  localparam int unsigned PresW = cnt_width(TICK_CYCLES - 1);
  localparam logic [PresW-1:0] PresLast = PresW'(TICK_CYCLES - 1);

  logic [PresW-1:0] pres_q, pres_d;
  logic             tick;

  assign tick = (pres_q == PresLast);

  // Prescaler next count: wrap to 0 after the tick cycle.
  always_comb begin
    pres_d = pres_q + 1'b1;
    if (tick) begin
      pres_d = '0;
    end
  end

  // Free-running prescaler register.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      pres_q <= '0;
    end else begin
      pres_q <= pres_d;
    end
  end

  for (genvar i = 0; i < int'(N); i++) begin : g_chan
    debounce_channel #(
      .DebounceTicks    (DEBOUNCE_TICKS),
      .RepeatDelayTicks (REPEAT_DELAY_TICKS),
      .RepeatRateTicks  (REPEAT_RATE_TICKS)
    ) u_chan (
      .clk_i     (CLOCK_50),
      .rst_ni    (RESET_N),
      .tick_i    (tick),
      .button_ni (BUTTON_N[i]),
      .level_o   (BTN_LEVEL[i]),
      .press_o   (BTN_PRESS[i]),
      .release_o (BTN_RELEASE[i])
    );
  end

endmodule

// File: tb/tb_button_debounce.sv
// Self-checking bench for button_debounce with short tick parameters.
module tb_button_debounce;

  localparam int N  = 3;
  localparam int T  = 4;
  localparam int D  = 3;
  localparam int RD = 5;
  localparam int RR = 2;

  logic         CLOCK_50 = 1'b0;
  logic         RESET_N  = 1'b0;
  logic [N-1:0] BUTTON_N = '1;
  logic [N-1:0] BTN_LEVEL, BTN_PRESS, BTN_RELEASE;

  int checks = 0;
  int errors = 0;

  always #5 CLOCK_50 = ~CLOCK_50;

  button_debounce #(
    .N                  (N),
    .TICK_CYCLES        (T),
    .DEBOUNCE_TICKS     (D),
    .REPEAT_DELAY_TICKS (RD),
    .REPEAT_RATE_TICKS  (RR)
  ) dut (
    .CLOCK_50    (CLOCK_50),
    .RESET_N     (RESET_N),
    .BUTTON_N    (BUTTON_N),
    .BTN_LEVEL   (BTN_LEVEL),
    .BTN_PRESS   (BTN_PRESS),
    .BTN_RELEASE (BTN_RELEASE)
  );

  // Behavioural reference: accepted level, pending flag, ticks seen while pending,
  // ticks spent held, and a two-deep history of sampled pins.
  int           cyc;
  logic [N-1:0] p1, p2, lvl_m, pend_m, press_m, rel_m;
  int           n_m[N];
  int           h_m[N];

  task automatic check(input string name, input int act, input int want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, want, $time);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d..%0d (t=%0t)", name, act, lo, hi, $time);
    end
  endtask

  task automatic model_reset();
    cyc = 0;
    p1 = '1;
    p2 = '1;
    lvl_m = '0;
    pend_m = '0;
    press_m = '0;
    rel_m = '0;
    for (int i = 0; i < N; i++) begin
      n_m[i] = 0;
      h_m[i] = 0;
    end
  endtask

  task automatic model_edge();
    bit   tk;
    logic s;
    tk = ((cyc % T) == T - 1);
    for (int i = 0; i < N; i++) begin
      s = ~p2[i];
      press_m[i] = 1'b0;
      rel_m[i] = 1'b0;
      if (s != lvl_m[i]) begin
        if (!pend_m[i]) begin
          pend_m[i] = 1'b1;
          n_m[i] = 0;
        end else if (tk) begin
          n_m[i]++;
          if (n_m[i] == D) begin
            lvl_m[i] = s;
            pend_m[i] = 1'b0;
            if (s) begin
              press_m[i] = 1'b1;
              h_m[i] = 0;
            end else begin
              rel_m[i] = 1'b1;
            end
          end
        end
      end else if (pend_m[i]) begin
        pend_m[i] = 1'b0;
      end else if (lvl_m[i] && tk) begin
        h_m[i]++;
`ifdef BUTTON_DEBOUNCE_REPEAT_EN
        if (h_m[i] == RD || (h_m[i] > RD && ((h_m[i] - RD) % RR) == 0)) press_m[i] = 1'b1;
`endif
      end
    end
    p2 = p1;
    p1 = BUTTON_N;
    cyc++;
  endtask

  // One clock: advance the model with the pins present at the edge, compare #1 later.
  task automatic step();
    @(posedge CLOCK_50);
    model_edge();
    #1;
    check("model_level", int'(BTN_LEVEL), int'(lvl_m));
    check("model_press", int'(BTN_PRESS), int'(press_m));
    check("model_release", int'(BTN_RELEASE), int'(rel_m));
  endtask

  task automatic settle(input int n);
    BUTTON_N = '1;
    repeat (n) step();
  endtask

  task automatic do_reset();
    RESET_N = 1'b0;
    #1;
    check("rst_level", int'(BTN_LEVEL), 0);
    check("rst_press", int'(BTN_PRESS), 0);
    check("rst_release", int'(BTN_RELEASE), 0);
    @(posedge CLOCK_50);
    #1;
    RESET_N = 1'b1;
    model_reset();
  endtask

  typedef struct {
    logic [2:0] pins;
    logic [2:0] level;
    logic [2:0] press;
    logic [2:0] rel;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int k;
    int cnt_a;
    int cnt_b;
    int cnt_c;
    int want_n;
    logic [2:0] seen_p;
    logic [2:0] seen_r;
    int q[$];

    // Each channel is held for at most one 20-cycle vector, so no repeat can fire.
    vecs[0] = '{3'b110, 3'b001, 3'b001, 3'b000};
    vecs[1] = '{3'b101, 3'b010, 3'b010, 3'b001};
    vecs[2] = '{3'b011, 3'b100, 3'b100, 3'b010};
    vecs[3] = '{3'b100, 3'b011, 3'b011, 3'b100};
    vecs[4] = '{3'b111, 3'b000, 3'b000, 3'b011};
    vecs[5] = '{3'b010, 3'b101, 3'b101, 3'b000};
    vecs[6] = '{3'b111, 3'b000, 3'b000, 3'b101};

    model_reset();
    repeat (3) @(posedge CLOCK_50);
    #1;
    check("init_level", int'(BTN_LEVEL), 0);
    check("init_press", int'(BTN_PRESS), 0);
    check("init_release", int'(BTN_RELEASE), 0);
    RESET_N = 1'b1;
    model_reset();
    settle(8);

    // Clean press on channel 0.
    k = -1;
    cnt_a = 0;
    BUTTON_N[0] = 1'b0;
    for (int c = 0; c < 40; c++) begin
      step();
      if (BTN_PRESS[0]) begin
        cnt_a++;
        if (k < 0) begin
          k = c;
          check("press_level_rise", int'(BTN_LEVEL[0]), 1);
        end
      end
    end
    check_range("press_latency", k, 11, 14);
    want_n = 1;
`ifdef BUTTON_DEBOUNCE_REPEAT_EN
    if (k >= 0) for (int t = k + 20; t < 40; t += 8) want_n++;
`endif
    check("press_count", cnt_a, want_n);

    // Release of channel 0.
    k = -1;
    cnt_a = 0;
    BUTTON_N[0] = 1'b1;
    for (int c = 0; c < 30; c++) begin
      step();
      if (BTN_RELEASE[0]) begin
        cnt_a++;
        if (k < 0) begin
          k = c;
          check("release_level_fall", int'(BTN_LEVEL[0]), 0);
        end
      end
    end
    check_range("release_latency", k, 11, 14);
    check("release_count", cnt_a, 1);
    settle(4);

    // Bounce rejection on channel 1.
    cnt_a = 0;
    cnt_b = 0;
    cnt_c = 0;
    for (int c = 0; c < 80; c++) begin
      if (c < 60 && (c % 5) == 0) BUTTON_N[1] = ~BUTTON_N[1];
      if (c == 60) BUTTON_N[1] = 1'b1;
      step();
      cnt_a += int'(BTN_PRESS[1]);
      cnt_b += int'(BTN_RELEASE[1]);
      cnt_c += int'(BTN_LEVEL[1]);
    end
    check("bounce_press", cnt_a, 0);
    check("bounce_release", cnt_b, 0);
    check("bounce_level", cnt_c, 0);

    // Simultaneous press.
    settle(4);
    BUTTON_N = '0;
    k = -1;
    for (int c = 0; c < 30 && k < 0; c++) begin
      step();
      if (BTN_PRESS != '0) k = c;
    end
    check("simul_press", int'(BTN_PRESS), 3'b111);
    step();
    check("simul_press_width", int'(BTN_PRESS), 0);
    settle(24);

    // Table-driven vectors.
    for (int v = 0; v < 7; v++) begin
      BUTTON_N = vecs[v].pins;
      seen_p = '0;
      seen_r = '0;
      for (int c = 0; c < 20; c++) begin
        step();
        seen_p |= BTN_PRESS;
        seen_r |= BTN_RELEASE;
      end
      check($sformatf("vec%0d_level", v), int'(BTN_LEVEL), int'(vecs[v].level));
      check($sformatf("vec%0d_press", v), int'(seen_p), int'(vecs[v].press));
      check($sformatf("vec%0d_release", v), int'(seen_r), int'(vecs[v].rel));
    end
    settle(24);

    // Reset during PRESS_PEND on channel 2 while channel 0 is held.
    BUTTON_N[0] = 1'b0;
    repeat (16) step();
    BUTTON_N[2] = 1'b0;
    repeat (6) step();
    check("pre_reset_level0", int'(BTN_LEVEL[0]), 1);
    check("pre_reset_level2", int'(BTN_LEVEL[2]), 0);
    do_reset();
    cnt_a = 0;
    for (int c = 0; c < 30; c++) begin
      step();
      cnt_a += int'(BTN_PRESS[2]);
    end
    check("post_reset_press2", cnt_a, 1);
    settle(24);

    // Long hold: auto-repeat cadence, or a single pulse without it.
    q.delete();
    BUTTON_N[0] = 1'b0;
    for (int c = 0; c < 60; c++) begin
      step();
      if (BTN_PRESS[0]) q.push_back(c);
    end
`ifdef BUTTON_DEBOUNCE_REPEAT_EN
    want_n = 0;
    if (q.size() > 0) for (int t = q[0]; t < 60; t += (t == q[0]) ? 20 : 8) want_n++;
    check("repeat_count", q.size(), (q.size() > 0) ? want_n : 5);
    if (q.size() > 1) check("repeat_first_gap", q[1] - q[0], 20);
    for (int j = 2; j < q.size(); j++) check("repeat_gap", q[j] - q[j-1], 8);
`else
    check("hold_single_press", q.size(), 1);
`endif
    settle(24);

    // Random pin activity against the reference model.
    for (int c = 0; c < 700; c++) begin
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, (c < 300) ? 11 : 39) == 0) BUTTON_N[i] = ~BUTTON_N[i];
      end
      step();
    end
    settle(24);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
